instr_encoder_loader: RTL and testbench

- Encoder side of the RV32I control path: the control decoder turns instruction words into control signals; this block builds those instruction words.
- Accepts symbolic instruction commands (op, rd, rs1, rs2, imm) over a valid/ready handshake.
- Encodes each command into a 32-bit RV32I word and writes it sequentially into instruction memory through a write/ack port.
- Used to load test programs after reset, before the core is released.

---
 rtl/instr_encoder_loader.sv | 154 +++++++++++++++
 tb/tb_instr_encoder_loader.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader: encodes symbolic RV32I commands and writes them sequentially into instruction memory.
module instr_encoder_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MEM_WORDS = 256
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd_op,
  input  logic [4:0]  cmd_rd,
  input  logic [4:0]  cmd_rs1,
  input  logic [4:0]  cmd_rs2,
  input  logic [31:0] cmd_imm,
  input  logic        cmd_last,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  input  logic        imem_ack,
  output logic        done,
  output logic [2:0]  err,
  output logic [15:0] words_written
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ENC  = 2'd1;
  localparam logic [1:0] WR   = 2'd2;
  logic [1:0]  state_q, state_d;
  logic [3:0]  op_q, op_d;
  logic [4:0]  rd_q, rd_d, rs1_q, rs1_d, rs2_q, rs2_d;
  logic [31:0] imm_q, imm_d, addr_q, addr_d, wdata_q, wdata_d, enc;
  logic        last_q, last_d, done_q, done_d;
  logic [2:0]  err_q, err_d;
  logic [15:0] cnt_q, cnt_d;
  logic        ill, rng, full, i_ok, b_ok, j_ok;
  assign cmd_ready     = state_q == IDLE;
  assign imem_we       = state_q == WR;
  assign imem_addr     = addr_q;
  assign imem_wdata    = wdata_q;
  assign done          = done_q;
  assign err           = err_q;
  assign words_written = cnt_q;
  // Immediate fits when all bits above the field's sign bit match it.
  assign i_ok = &imm_q[31:11] | ~|imm_q[31:11];
  assign b_ok = (&imm_q[31:12] | ~|imm_q[31:12]) & ~imm_q[0];
  assign j_ok = (&imm_q[31:20] | ~|imm_q[31:20]) & ~imm_q[0];
  assign full = cnt_q == 16'(MEM_WORDS);
  always_comb begin
    enc = 32'h0;
    ill = 1'b0;
    rng = 1'b0;
    case (op_q)
      4'd0: enc = {7'b0000000, rs2_q, rs1_q, 3'b000, rd_q, 7'b0110011};
      4'd1: enc = {7'b0100000, rs2_q, rs1_q, 3'b000, rd_q, 7'b0110011};
      4'd2: enc = {7'b0000000, rs2_q, rs1_q, 3'b111, rd_q, 7'b0110011};
      4'd3: enc = {7'b0000000, rs2_q, rs1_q, 3'b110, rd_q, 7'b0110011};
      4'd4: enc = {7'b0000000, rs2_q, rs1_q, 3'b100, rd_q, 7'b0110011};
      4'd5: enc = {7'b0000000, rs2_q, rs1_q, 3'b010, rd_q, 7'b0110011};
      4'd6: begin
        enc = {imm_q[11:0], rs1_q, 3'b000, rd_q, 7'b0010011};
        rng = ~i_ok;
      end
      4'd7, 4'd8: begin
        enc = {imm_q[12], imm_q[10:5], rs2_q, rs1_q, {2'b00, op_q == 4'd8}, imm_q[4:1], imm_q[11], 7'b1100011};
        rng = ~b_ok;
      end
      4'd9: begin
        enc = {imm_q[20], imm_q[10:1], imm_q[11], imm_q[19:12], rd_q, 7'b1101111};
        rng = ~j_ok;
      end
      4'd10: begin
        enc = {imm_q[11:0], rs1_q, 3'b000, rd_q, 7'b1100111};
        rng = ~i_ok;
      end
      4'd11: begin
        enc = {imm_q[11:0], rs1_q, 3'b010, rd_q, 7'b0000011};
        rng = ~i_ok;
      end
      4'd12: begin
        enc = {imm_q[11:5], rs2_q, rs1_q, 3'b010, imm_q[4:0], 7'b0100011};
        rng = ~i_ok;
      end
      default: ill = 1'b1;
    endcase
  end
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    rd_d    = rd_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    imm_d   = imm_q;
    last_d  = last_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: if (cmd_valid) begin
        op_d    = cmd_op;
        rd_d    = cmd_rd;
        rs1_d   = cmd_rs1;
        rs2_d   = cmd_rs2;
        imm_d   = cmd_imm;
        last_d  = cmd_last;
        state_d = ENC;
      end
      ENC: if (ill | rng | full) begin
        err_d   = err_q | (ill ? 3'b001 : rng ? 3'b010 : 3'b100);
        done_d  = last_q;
        state_d = IDLE;
      end else begin
        wdata_d = enc;
        state_d = WR;
      end
      WR: if (imem_ack) begin
        addr_d  = last_q ? BASE_ADDR : addr_q + 32'd4;
        cnt_d   = last_q ? 16'd0 : cnt_q + 16'd1;
        done_d  = last_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= IDLE;
      op_q    <= 4'd0;
      rd_q    <= 5'd0;
      rs1_q   <= 5'd0;
      rs2_q   <= 5'd0;
      imm_q   <= 32'h0;
      last_q  <= 1'b0;
      addr_q  <= BASE_ADDR;
      wdata_q <= 32'h0;
      cnt_q   <= 16'd0;
      err_q   <= 3'b000;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      rd_q    <= rd_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      imm_q   <= imm_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end
endmodule

// File: tb/tb_instr_encoder_loader.sv
// tb_instr_encoder_loader: randomized and directed scoreboard bench for the RV32I program loader.
module tb_instr_encoder_loader;
  localparam int MW = 8;
  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_last = 1'b0;
  logic [3:0]  cmd_op = 4'd0;
  logic [4:0]  cmd_rd = 5'd0, cmd_rs1 = 5'd0, cmd_rs2 = 5'd0;
  logic [31:0] cmd_imm = 32'h0;
  logic        imem_we, imem_ack, done;
  logic [31:0] imem_addr, imem_wdata;
  logic [2:0]  err;
  logic [15:0] words_written;
  int checks = 0, errors = 0;
  typedef struct { logic [31:0] addr; logic [31:0] data; } wr_t;
  typedef struct { logic [2:0] err; logic [15:0] cnt; logic [31:0] addr; } dn_t;
  wr_t wq[$];
  dn_t dq[$];
  logic [31:0] addr_m;
  logic [15:0] cnt_m;
  logic [2:0]  err_m;
  bit hold_ack = 1'b0;
  int dly = 0;
  instr_encoder_loader #(.BASE_ADDR(32'h0), .MEM_WORDS(MW)) dut (
    .clk(clk), .nrst(nrst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_rd(cmd_rd), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2),
    .cmd_imm(cmd_imm), .cmd_last(cmd_last), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .imem_ack(imem_ack), .done(done), .err(err),
    .words_written(words_written)
  );
  always #5 clk = ~clk;
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  // Reference encoder built from the instruction-format field positions.
  function automatic logic [31:0] ref_enc(logic [31:0] op, logic [31:0] rd, logic [31:0] rs1, logic [31:0] rs2, logic [31:0] u);
    logic [31:0] f3r [6] = '{0, 0, 7, 6, 4, 2};
    if (op <= 5) return ((op == 1 ? 32'h20 : 32'h0) << 25) | (rs2 << 20) | (rs1 << 15) | (f3r[op] << 12) | (rd << 7) | 32'h33;
    if (op == 6) return ((u & 32'hfff) << 20) | (rs1 << 15) | (rd << 7) | 32'h13;
    if (op == 10) return ((u & 32'hfff) << 20) | (rs1 << 15) | (rd << 7) | 32'h67;
    if (op == 11) return ((u & 32'hfff) << 20) | (rs1 << 15) | (32'd2 << 12) | (rd << 7) | 32'h03;
    if (op == 12) return (((u >> 5) & 32'h7f) << 25) | (rs2 << 20) | (rs1 << 15) | (32'd2 << 12) | ((u & 32'h1f) << 7) | 32'h23;
    if (op == 9) return (((u >> 20) & 1) << 31) | (((u >> 1) & 32'h3ff) << 21) | (((u >> 11) & 1) << 20) | (((u >> 12) & 32'hff) << 12) | (rd << 7) | 32'h6f;
    return (((u >> 12) & 1) << 31) | (((u >> 5) & 32'h3f) << 25) | (rs2 << 20) | (rs1 << 15) | ((op - 7) << 12) | (((u >> 1) & 32'hf) << 8) | (((u >> 11) & 1) << 7) | 32'h63;
  endfunction
  function automatic bit ref_range_bad(int op, int imm);
    if (op == 6 || op >= 10) return imm < -2048 || imm > 2047;
    if (op == 7 || op == 8) return imm < -4096 || imm > 4094 || imm[0];
    if (op == 9) return imm < -1048576 || imm > 1048574 || imm[0];
    return 1'b0;
  endfunction
  task automatic model_reset();
    addr_m = 32'h0;
    cnt_m = 16'd0;
    err_m = 3'b000;
    wq.delete();
    dq.delete();
  endtask
  task automatic do_reset();
    nrst = 1'b0;
    hold_ack = 1'b0;
    dly = 0;
    repeat (2) @(negedge clk);
    model_reset();
    nrst = 1'b1;
  endtask
  task automatic send(int op, int rd, int rs1, int rs2, int imm, bit last, bit use_x, logic [31:0] xw, output int lat);
    int n;
    wr_t w;
    dn_t d;
    bit bad;
    lat = -1;
    @(negedge clk);
    cmd_op = 4'(op); cmd_rd = 5'(rd); cmd_rs1 = 5'(rs1); cmd_rs2 = 5'(rs2);
    cmd_imm = imm; cmd_last = last; cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      chk("accept_timeout", 32'd0, 32'd1);
      cmd_valid = 1'b0;
      return;
    end
    bad = 1'b1;
    if (op > 12) err_m |= 3'b001;
    else if (ref_range_bad(op, imm)) err_m |= 3'b010;
    else if (cnt_m == 16'(MW)) err_m |= 3'b100;
    else bad = 1'b0;
    if (!bad) begin
      w.addr = addr_m;
      w.data = use_x ? xw : ref_enc(op, rd, rs1, rs2, imm);
      wq.push_back(w);
      addr_m += 4;
      cnt_m++;
      if (last) begin
        addr_m = 32'h0;
        cnt_m = 16'd0;
      end
    end
    if (last) begin
      d.err = err_m; d.cnt = cnt_m; d.addr = addr_m;
      dq.push_back(d);
    end
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 1;
    while (!cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    lat = n;
  endtask
  task automatic drain();
    int n = 0;
    while (!(cmd_ready && wq.size() == 0 && dq.size() == 0) && n < 300) begin
      @(negedge clk);
      #3;
      n++;
    end
    if (n >= 300) chk("drain_timeout", 32'd0, 32'd1);
  endtask
  initial begin
    imem_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (imem_we && !hold_ack && !imem_ack) begin
        if (dly == 0) begin
          imem_ack = 1'b1;
          dly = $urandom_range(0, 4);
        end else dly--;
      end else imem_ack = 1'b0;
    end
  end
  // Monitor: compares every presented write and every done pulse with the scoreboard.
  initial begin
    wr_t w;
    dn_t d;
    forever begin
      @(negedge clk);
      #2;
      if (!nrst) continue;
      if (imem_we) begin
        chk("ready_during_wr", 32'(cmd_ready), 32'd0);
        if (wq.size() == 0) chk("unexpected_write", 32'd1, 32'd0);
        else begin
          w = wq[0];
          chk("wr_addr", imem_addr, w.addr);
          chk("wr_data", imem_wdata, w.data);
          if (imem_ack) void'(wq.pop_front());
        end
      end
      if (done) begin
        if (dq.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
        else begin
          d = dq.pop_front();
          chk("done_err", 32'(err), 32'(d.err));
          chk("done_words", 32'(words_written), 32'(d.cnt));
          chk("done_addr", imem_addr, d.addr);
        end
      end
    end
  end
  initial begin
    int lat, op, imm;
    model_reset();
    do_reset();
    @(negedge clk);
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    chk("rst_we", 32'(imem_we), 32'd0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_wdata", imem_wdata, 32'h0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_words", 32'(words_written), 32'd0);
    dly = 0;
    send(0, 3, 1, 2, 0, 0, 1, 32'h002081B3, lat);
    chk("add_ready_latency", lat, 3);
    drain();
    chk("add_words", 32'(words_written), 32'd1);
    do_reset();
    send(1, 5, 6, 7, 0, 0, 1, 32'h407302B3, lat);
    send(6, 1, 0, 0, -1, 0, 1, 32'hFFF00093, lat);
    dly = 4;
    send(8, 0, 1, 2, -8, 0, 1, 32'hFE209CE3, lat);
    chk("delayed_ack_latency", lat, 7);
    send(12, 0, 1, 2, 8, 0, 1, 32'h0020A423, lat);
    send(9, 1, 0, 0, 16, 1, 1, 32'h010000EF, lat);
    drain();
    chk("seq_addr_back", imem_addr, 32'h0);
    do_reset();
    for (int i = 0; i < 150; i++) begin
      op = $urandom_range(0, 15);
      case ($urandom_range(0, 3))
        0: imm = int'($urandom_range(0, 4200)) - 2100;
        1: imm = int'($urandom_range(0, 9000)) - 4500;
        2: imm = int'($urandom_range(0, 2200000)) - 1100000;
        default: imm = int'($urandom);
      endcase
      send(op, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31), imm, $urandom_range(0, 3) == 0, 0, 32'h0, lat);
    end
    drain();
    chk("rand_err", 32'(err), 32'(err_m));
    chk("rand_words", 32'(words_written), 32'(cnt_m));
    do_reset();
    for (int i = 0; i < MW; i++) send(2, i, i + 1, i + 2, 0, 0, 0, 32'h0, lat);
    send(3, 1, 1, 1, 0, 1, 0, 32'h0, lat);
    drain();
    chk("full_err", 32'(err), 32'd4);
    chk("full_words", 32'(words_written), 32'(MW));
    chk("full_addr", imem_addr, 32'(4 * MW));
    do_reset();
    send(6, 1, 0, 0, 2048, 0, 0, 32'h0, lat);
    send(14, 1, 2, 3, 0, 0, 0, 32'h0, lat);
    send(7, 0, 1, 2, 3, 0, 0, 32'h0, lat);
    drain();
    chk("illegal_range_err", 32'(err), 32'd3);
    chk("illegal_range_addr", imem_addr, 32'h0);
    chk("illegal_range_words", 32'(words_written), 32'd0);
    hold_ack = 1'b1;
    @(negedge clk);
    cmd_op = 4'd0; cmd_rd = 5'd1; cmd_rs1 = 5'd2; cmd_rs2 = 5'd3; cmd_last = 1'b0; cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    wq.push_back('{addr: 32'h0, data: ref_enc(0, 1, 2, 3, 0)});
    for (int n = 0; n < 20 && !imem_we; n++) @(negedge clk);
    chk("midwr_we_high", 32'(imem_we), 32'd1);
    #1 nrst = 1'b0;
    #2;
    chk("midwr_ready", 32'(cmd_ready), 32'd1);
    chk("midwr_we", 32'(imem_we), 32'd0);
    chk("midwr_addr", imem_addr, 32'h0);
    chk("midwr_wdata", imem_wdata, 32'h0);
    chk("midwr_done", 32'(done), 32'd0);
    chk("midwr_err", 32'(err), 32'd0);
    chk("midwr_words", 32'(words_written), 32'd0);
    model_reset();
    hold_ack = 1'b0;
    @(negedge clk);
    nrst = 1'b1;
    repeat (3) @(negedge clk);
    chk("leftover_writes", wq.size(), 0);
    chk("leftover_dones", dq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
